// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg -- shared gate encodings, FSM states and sweep constants.
// Rev 1.0
`default_nettype none

package gate_sweep_pkg;

  localparam logic [1:0] GATE_OR2   = 2'd0;
  localparam logic [1:0] GATE_AND2  = 2'd1;
  localparam logic [1:0] GATE_NAND2 = 2'd2;
  localparam logic [1:0] GATE_XOR2  = 2'd3;

  localparam int NUM_VEC = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_sequencer_if.sv
// gate_sweep_sequencer_if -- controller and gate-under-test signals of the sweep sequencer.
// Rev 1.0
`default_nettype none

interface gate_sweep_sequencer_if #(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic [1:0]       gate_sel;
  logic [CNT_W-1:0] repeats;
  logic             dut_o;
  logic             dut_a;
  logic             dut_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       fail_vec;

  // master = test controller plus the gate under test; slave = sequencer
  modport master (
    output start, gate_sel, repeats, dut_o,
    input  dut_a, dut_b, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start, gate_sel, repeats, dut_o,
    output dut_a, dut_b, busy, done, pass, err_cnt, fail_vec
  );

endinterface

`default_nettype wire

// File: rtl/gate_expect.sv
// gate_expect -- reference truth tables for the supported 2-input gates.
// Rev 1.0
`default_nettype none

module gate_expect
  import gate_sweep_pkg::*;
(
  input  wire logic [1:0] gate_sel,
  input  wire logic       a,
  input  wire logic       b,
  output logic            o
);

  always_comb begin
    o = 1'b0;
    case (gate_sel)
      GATE_OR2:   o = a | b;
      GATE_AND2:  o = a & b;
      GATE_NAND2: o = ~(a & b);
      GATE_XOR2:  o = a ^ b;
      default:    o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_sweep_sequencer.sv
// gate_sweep_sequencer -- drives all four input vectors of a 2-input gate, checks it, counts mismatches.
// Rev 1.0
`default_nettype none

module gate_sweep_sequencer
  import gate_sweep_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input wire logic              clk,
  input wire logic              rst,
  gate_sweep_sequencer_if.slave bus
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] c_SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_reps;
  logic [CNT_W-1:0] r_sweep;
  logic [1:0]       r_idx;
  logic [SET_W-1:0] r_settle;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err;
  logic [3:0]       r_fv;

  logic             w_accept;
  logic             w_exp;
  logic             w_mismatch;
  logic             w_more_sweeps;
  logic             w_last_vec;

  gate_expect u_expect (
    .gate_sel (r_sel),
    .a        (r_a),
    .b        (r_b),
    .o        (w_exp)
  );

  assign w_accept      = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_mismatch    = (bus.dut_o != w_exp);
  assign w_last_vec    = (r_idx == 2'(NUM_VEC - 1));
  assign w_more_sweeps = ({1'b0, r_sweep} + (CNT_W+1)'(1)) < {1'b0, r_reps};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_next = (bus.repeats == '0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY:  w_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE: begin
        if (r_settle == c_SETTLE_LAST) begin
          w_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: w_next = (!w_last_vec || w_more_sweeps) ? ST_APPLY : ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered, so done/pass and the cleared gate inputs appear
  // one cycle after the state register reaches DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= '0;
      r_reps   <= '0;
      r_sweep  <= '0;
      r_idx    <= '0;
      r_settle <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fv     <= '0;
    end else if (w_accept) begin
      r_sel    <= bus.gate_sel;
      r_reps   <= bus.repeats;
      r_sweep  <= '0;
      r_idx    <= '0;
      r_settle <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= (bus.repeats != '0);
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fv     <= '0;
    end else begin
      case (r_state)
        ST_APPLY: begin
          r_a      <= r_idx[1];
          r_b      <= r_idx[0];
          r_settle <= '0;
        end
        ST_SETTLE: r_settle <= r_settle + 1'b1;
        ST_SAMPLE: begin
          if (w_mismatch) begin
            if (r_err != '1) begin
              r_err <= r_err + 1'b1;
            end
            r_fv[r_idx] <= 1'b1;
          end
          if (!w_last_vec) begin
            r_idx <= r_idx + 1'b1;
          end else if (w_more_sweeps) begin
            r_idx   <= '0;
            r_sweep <= r_sweep + 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_DONE: begin
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          r_done <= 1'b1;
          r_pass <= (r_err == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_a    = r_a;
  assign bus.dut_b    = r_b;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.err_cnt  = r_err;
  assign bus.fail_vec = r_fv;

endmodule

`default_nettype wire

// File: doc/gate_sweep_sequencer.md
Name: gate_sweep_sequencer

Overview:
- Sequences exhaustive functional sweeps of one external 2-input gate under test (or2, and2, nand2 or xor2).
- Drives all four input vectors in order, waits a settle interval, samples the gate output and compares it with the expected truth table for the selected gate type.
- Accumulates mismatch statistics and sits between the test controller and the gate instance in the characterisation bench.

Parameters:
CNT_W, 16, width of the sweep repeat count and of the error counter
SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling dut_o; 0 is legal

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a run; accepted only when busy=0
gate_sel  input  2  gate type: 0=or2, 1=and2, 2=nand2, 3=xor2; latched on accepted start
repeats  input  CNT_W  number of full 4-vector sweeps; latched on accepted start
dut_o  input  1  output of the gate under test
dut_a  output  1  gate input a (registered)
dut_b  output  1  gate input b (registered)
busy  output  1  high from the cycle after an accepted start until DONE is entered
done  output  1  high while in DONE; held until next accepted start
pass  output  1  valid when done=1; 1 iff err_cnt==0
err_cnt  output  CNT_W  total mismatches, saturating at all-ones
fail_vec  output  4  sticky per-vector fail flag; bit index = {a,b}

Behaviour:
- Reset (async, any state): state=IDLE; dut_a=dut_b=0; busy=done=pass=0; err_cnt=0; fail_vec=0; latched gate_sel, repeats, vector index and settle counter cleared.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1: latch gate_sel and repeats; clear err_cnt, fail_vec, pass and done; vector index=0, sweep count=0.
  - If repeats==0, go to DONE with pass=1.
  - Otherwise go to APPLY with busy=1.
- APPLY, 1 cycle: dut_a/dut_b take vector bits {a,b}=index (order 00,01,10,11). Next state is SETTLE, or SAMPLE if SETTLE_CYCLES==0.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE, 1 cycle: compare dut_o with expected(gate_sel, a, b). On mismatch, err_cnt+1 (saturating) and fail_vec[index] set. Then:
  - index<3: index+1, go to APPLY.
  - index==3, sweep count+1 < repeats: index=0, sweep count+1, go to APPLY.
  - Otherwise go to DONE.
- Per-vector cost is SETTLE_CYCLES+2 cycles. For a run of R sweeps, done rises 1 + 4·R·(SETTLE_CYCLES+2) cycles after the start-accept edge.
- DONE: dut_a=dut_b=0; busy=0; done=1; pass=(err_cnt==0). err_cnt and fail_vec are held until the next accepted start.
- start while busy: ignored, with no effect on latched configuration.
- gate_sel and repeats changes mid-run: ignored.
- dut_o is sampled only in SAMPLE.
- Expected-output function:
  - or2: a|b
  - and2: a&b
  - nand2: ~(a&b)
  - xor2: a^b
- err_cnt saturates at 2^CNT_W−1 and does not wrap.

Decomposition:
- Shared package gate_sweep_pkg:
  - gate_sel encodings (GATE_OR2, GATE_AND2, GATE_NAND2, GATE_XOR2)
  - state enum
  - vector count constant NUM_VEC=4
- One combinational sub-module, gate_expect (inputs gate_sel, a, b; output o), holding the reference truth tables. It is reusable by other benches.
- FSM, counters and comparator stay in gate_sweep_sequencer.

Test Plan:
- Correct nand2 DUT, gate_sel=2, repeats=3, SETTLE_CYCLES=2 -> dut_a/dut_b cycle 00,01,10,11 three times. done rises 49 cycles after start accept; err_cnt=0, fail_vec=0000, pass=1.
- and2 DUT wired, gate_sel=2 (nand2), repeats=5 -> err_cnt=20, fail_vec=1111, pass=0.
- or2 DUT wired, gate_sel=3 (xor2), repeats=4 -> only vector 11 fails; err_cnt=4, fail_vec=1000, pass=0.
- repeats=0, any gate_sel -> done and pass high on the cycle after start; busy never asserted; dut_a=dut_b=0 throughout.
- Running xor2 sweep, repeats=10: pulse start and change gate_sel mid-run -> ignored, final err_cnt=0. Then assert rst mid-sweep -> all outputs zero immediately (async), IDLE. A fresh start then runs normally.
- CNT_W=3, mismatching DUT, repeats=4 -> err_cnt saturates at 7 with no wrap; fail_vec=1111.
